// File: rtl/short_fifo_pkg.sv
// Shared sizing helpers and the oversize-packet drain state for the short FIFO family.
package short_fifo_pkg;

  typedef enum logic {IDLE, DRAIN} drain_state_t;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic int count_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, contents never reset.
module fifo_ram #(
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 17
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [1 << ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/packet_short_fifo.sv
// Single-clock valid/ready FIFO with fill count, almost flags and last sideband.
// Optional packet mode holds output back until a whole packet is stored.
module packet_short_fifo
  import short_fifo_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16,
  parameter int AF_LEVEL = (1 << ADDR_W) - 2,
  parameter int AE_LEVEL = 2,
  parameter int PKT_MODE = 0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                inValid,
  output logic                inReady,
  input  logic [DATA_W-1:0]   dIn,
  input  logic                inLast,
  output logic                outValid,
  input  logic                outReady,
  output logic [DATA_W-1:0]   dOut,
  output logic                outLast,
  output logic [ADDR_W:0]     count,
  output logic                almostFull,
  output logic                almostEmpty
);

  localparam int CW = count_width(ADDR_W);
  localparam logic [CW-1:0] FULL = CW'(fifo_depth(ADDR_W));

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]     count_q, pkt_cnt;
  drain_state_t      state;
  logic [DATA_W:0]   rd_word;
  logic              wr, rd, pkt_in, pkt_out;

  assign inReady  = rstn && (count_q != FULL);
  // In packet mode a stuck-full FIFO with no complete packet must still drain.
  assign outValid = (count_q != '0) &&
                    ((PKT_MODE == 0) || (pkt_cnt != '0) || (state == DRAIN));

  assign wr      = inValid && inReady;
  assign rd      = outValid && outReady;
  assign pkt_in  = wr && inLast;
  assign pkt_out = rd && outLast;

  fifo_ram #(.ADDR_W(ADDR_W), .WIDTH(DATA_W + 1)) u_ram (
    .clk   (clk),
    .we    (wr),
    .waddr (wr_ptr),
    .wdata ({inLast, dIn}),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  assign dOut    = rd_word[DATA_W-1:0];
  assign outLast = rd_word[DATA_W];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      pkt_cnt <= '0;
      state   <= IDLE;
    end else begin
      if (wr) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd) rd_ptr <= rd_ptr + ADDR_W'(1);

      if (wr && !rd)      count_q <= count_q + CW'(1);
      else if (!wr && rd) count_q <= count_q - CW'(1);

      if (pkt_in && !pkt_out)      pkt_cnt <= pkt_cnt + CW'(1);
      else if (!pkt_in && pkt_out) pkt_cnt <= pkt_cnt - CW'(1);

      case (state)
        IDLE:    if ((PKT_MODE != 0) && (count_q == FULL) && (pkt_cnt == '0)) state <= DRAIN;
        DRAIN:   if (pkt_out) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign count       = count_q;
  assign almostFull  = count_q >= CW'(AF_LEVEL);
  assign almostEmpty = count_q <= CW'(AE_LEVEL);

endmodule

// File: tb/tb_packet_short_fifo.sv
// Randomised and directed bench for packet_short_fifo in streaming and packet modes against a queue model.
module tb_packet_short_fifo;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        iv0 = 0, ir0, il0 = 0, ov0, or0 = 0, ol0, af0, ae0;
  logic [15:0] din0 = '0, dout0;
  logic [4:0]  cnt0;
  logic        iv1 = 0, ir1, il1 = 0, ov1, or1 = 0, ol1, af1, ae1;
  logic [15:0] din1 = '0, dout1;
  logic [4:0]  cnt1;

  packet_short_fifo #(.PKT_MODE(0)) dut0 (
    .clk(clk), .rstn(rstn), .inValid(iv0), .inReady(ir0), .dIn(din0), .inLast(il0),
    .outValid(ov0), .outReady(or0), .dOut(dout0), .outLast(ol0), .count(cnt0),
    .almostFull(af0), .almostEmpty(ae0));

  packet_short_fifo #(.PKT_MODE(1)) dut1 (
    .clk(clk), .rstn(rstn), .inValid(iv1), .inReady(ir1), .dIn(din1), .inLast(il1),
    .outValid(ov1), .outReady(or1), .dOut(dout1), .outLast(ol1), .count(cnt1),
    .almostFull(af1), .almostEmpty(ae1));

  int checks = 0;
  int errors = 0;
  logic [16:0] q[$];
  bit drn = 0;
  bit acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle on the selected DUT: drive, compare against the model, clock, update the model.
  task automatic step(input bit m, input bit iv, input logic [15:0] d, input bit il,
                      input bit ordy, output bit accepted);
    bit exp_ir, exp_ov, has_last, rd, nd;
    int n;
    iv0 = m ? 1'b0 : iv;  din0 = d; il0 = il; or0 = m ? 1'b0 : ordy;
    iv1 = m ? iv : 1'b0;  din1 = d; il1 = il; or1 = m ? ordy : 1'b0;
    #1;
    n = q.size();
    has_last = 0;
    foreach (q[i]) if (q[i][16]) has_last = 1;
    exp_ir = rstn && (n != 16);
    exp_ov = (n != 0) && (!m || has_last || drn);
    chk("in_ready",     m ? ir1 : ir0,   exp_ir);
    chk("out_valid",    m ? ov1 : ov0,   exp_ov);
    chk("count",        m ? cnt1 : cnt0, n);
    chk("almost_full",  m ? af1 : af0,   n >= 14);
    chk("almost_empty", m ? ae1 : ae0,   n <= 2);
    if (exp_ov) begin
      chk("dout",     m ? dout1 : dout0, q[0][15:0]);
      chk("out_last", m ? ol1 : ol0,     q[0][16]);
    end
    accepted = iv && exp_ir;
    rd = exp_ov && ordy;
    @(posedge clk);
    if (rstn) begin
      nd = drn;
      if (m && !drn && n == 16 && !has_last) nd = 1;
      else if (drn && rd && q[0][16]) nd = 0;
      drn = nd;
      if (rd) void'(q.pop_front());
      if (accepted) q.push_back({il, d});
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 0;
    q.delete();
    drn = 0;
    step(0, 1, 16'h1, 0, 1, acc);
    step(1, 1, 16'h1, 1, 1, acc);
    rstn = 1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Fill to full with reads held off, try one more, then full + simultaneous read.
    for (int i = 0; i < 16; i++) step(0, 1, 16'(i), 0, 0, acc);
    step(0, 1, 16'h99, 0, 0, acc);
    step(0, 1, 16'hC8, 0, 1, acc);
    step(0, 1, 16'hC8, 0, 0, acc);
    for (int i = 0; i < 18; i++) step(0, 0, 16'h0, 0, 1, acc);

    // Continuous streaming, one word per cycle.
    for (int i = 0; i < 1000; i++) step(0, 1, 16'(i), 0, 1, acc);
    for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 0, 1, acc);

    // Random streaming traffic, bursty ready to visit full and empty.
    for (int i = 0; i < 2000; i++)
      step(0, $urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 1) == 1,
           (i / 64) % 2 == 0 ? $urandom_range(0, 4) == 0 : $urandom_range(0, 4) != 0, acc);

    do_reset();
    // Packet mode: 5-word packet held until its last word lands.
    for (int i = 0; i < 5; i++) step(1, 1, 16'hA0 + 16'(i), i == 4, 1, acc);
    for (int i = 0; i < 8; i++) step(1, 0, 16'h0, 0, 1, acc);

    // Oversize packet forces the drain escape.
    begin
      int k = 0, guard = 0;
      while (k < 20 && guard < 200) begin
        step(1, 1, 16'h100 + 16'(k), k == 19, 1, acc);
        if (acc) k++;
        guard++;
      end
      chk("pkt20_words", k, 20);
    end
    for (int i = 0; i < 20; i++) step(1, 0, 16'h0, 0, 1, acc);
    // After the drain ends, a lone unterminated word must be held back.
    step(1, 1, 16'h77, 0, 1, acc);
    step(1, 0, 16'h0, 0, 1, acc);
    step(1, 1, 16'h78, 1, 1, acc);
    for (int i = 0; i < 4; i++) step(1, 0, 16'h0, 0, 1, acc);

    // Random packet traffic.
    for (int i = 0; i < 3000; i++)
      step(1, $urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 7) == 0,
           (i / 80) % 2 == 0 ? $urandom_range(0, 5) == 0 : $urandom_range(0, 3) != 0, acc);

    // Reset in the middle of a transfer discards everything stored.
    do_reset();
    for (int i = 0; i < 7; i++) step(0, 1, 16'h30 + 16'(i), 0, 0, acc);
    rstn = 0;
    q.delete();
    drn = 0;
    step(0, 1, 16'h3F, 0, 1, acc);
    rstn = 1;
    step(0, 1, 16'h55, 0, 0, acc);
    step(0, 0, 16'h0, 0, 1, acc);
    step(0, 0, 16'h0, 0, 1, acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/packet_short_fifo.md
# packet_short_fifo

Parametrised successor to the single-clock short FIFO: same valid/ready streaming interface, extended with a fill-level count, programmable almost-full/almost-empty flags and a `last` sideband bit. An optional packet mode withholds output until a complete packet is stored. It sits between AXI-Stream style producers and consumers that must not see partial packets.

## Interface
- `ADDR_W`, 4, depth is 2^ADDR_W entries (ADDR_W ≥ 1)
- `DATA_W`, 16, payload width
- `AF_LEVEL`, 2^ADDR_W-2, almostFull asserts when count ≥ AF_LEVEL (1..2^ADDR_W)
- `AE_LEVEL`, 2, almostEmpty asserts when count ≤ AE_LEVEL (0..2^ADDR_W-1)
- `PKT_MODE`, 0, 1 = release data only per complete packet
- `clk`  in  1  clock, all logic on rising edge
- `rstn`  in  1  reset; one clock; reset is asynchronous and active-low
- `inValid`  in  1  dIn/inLast valid
- `inReady`  out  1  FIFO can accept a word
- `dIn`  in  DATA_W  write data
- `inLast`  in  1  word ends a packet
- `outValid`  out  1  dOut/outLast valid
- `outReady`  in  1  consumer accepts word
- `dOut`  out  DATA_W  read data
- `outLast`  out  1  word ends a packet
- `count`  out  ADDR_W+1  stored words, 0..2^ADDR_W
- `almostFull`  out  1  count ≥ AF_LEVEL
- `almostEmpty`  out  1  count ≤ AE_LEVEL

## Operation
- Write on inValid && inReady; read on outValid && outReady; both may occur in one cycle.
- Storage is 2^ADDR_W × (DATA_W+1) words {inLast, dIn}; write/read pointers ADDR_W bits, wrap modulo depth naturally.
- count: +1 on write only, −1 on read only, unchanged on both or neither; never exceeds 2^ADDR_W or goes below 0.
- inReady = rstn && count != 2^ADDR_W. Full + read in same cycle: no write that cycle (inReady already low).
- PKT_MODE=0: outValid = count != 0.
- PKT_MODE=1: pktCount (ADDR_W+1 bits) counts stored words with last=1; +1 on write with inLast, −1 on read with outLast, unchanged if both.
- Oversize-packet escape, 1-bit `draining` state: IDLE→DRAIN when count == 2^ADDR_W and pktCount == 0; DRAIN→IDLE on read of word with outLast=1.
- PKT_MODE=1: outValid = count != 0 && (pktCount != 0 || draining).
- Once outValid is high it stays high with dOut/outLast stable until read.
- Memory contents are not reset; outputs from empty FIFO are don't-care with outValid low.

## Timing
- Reset (async assert): pointers, count, pktCount, draining cleared; inReady=0 while rstn low, 1 the first cycle after release; outValid=0, count=0, almostFull=0 (AF_LEVEL ≥ 1), almostEmpty=1, dOut/outLast undefined.
- Reset mid-packet discards all stored data; no partial word survives.
- Write-to-read latency: word written at edge N drives outValid high after edge N (visible cycle N+1); no combinational inValid→outValid path.
- PKT_MODE=1: outValid rises the cycle after the inLast word is written.
- count, almostFull, almostEmpty registered/derived from registers; update the cycle after the handshake.
- No combinational path from outReady to inReady or inValid to outValid.

## Structure
- Package `short_fifo_pkg`: depth function (2^ADDR_W), count width constant helper, draining state enum {IDLE, DRAIN}.
- One sub-module `fifo_ram`: simple dual-port memory, synchronous write, asynchronous read, width DATA_W+1, depth 2^ADDR_W; control/pointers/count in the top block.

## Test plan
- Reset then 16 writes of 0..15 with outReady=0 (ADDR_W=4): inReady drops after 16th, count=16, almostFull=1 from count=14; then drain reads 0..15 in order, almostEmpty=1 at count ≤2.
- Continuous inValid=outReady=1 for 1000 words counting 0..999: one word/cycle steady state, output sequence exact, count stays ≤1.
- Full FIFO with simultaneous inValid/outReady: one read, no write that cycle, count 16→15, next cycle write accepted.
- PKT_MODE=1, 5-word packet 0xA0..0xA4 with last on 0xA4, outReady=1: outValid stays 0 until cycle after 0xA4 written, then 5 words out, outLast only on 0xA4.
- PKT_MODE=1, 20-word packet without last: at count=16 DRAIN entered, outValid=1, words stream through; state returns IDLE after last word read.
- Assert rstn low mid-transfer with count=7: next cycle count=0, outValid=0; new word 0x55 after release is the first word read.
